// File: rtl/key_debouncer_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | key_debouncer_pkg                                                        |
// | Shared constants, per-channel event type and width helper for the keys.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package key_debouncer_pkg;

    localparam int DEBOUNCE_CYCLES_20MS_100MHZ = 2000000;
    localparam int DEBOUNCE_CYCLES_SIM         = 4;

    // Consumed by the downstream short/long-press detector (1 s at 100 MHz).
    localparam int LONG_PRESS_CYCLES_1S_100MHZ = 100000000;

    typedef struct packed {
        logic level;
        logic rise;
        logic fall;
    } key_event_t;

    // Ceiling log2; returns 0 for value <= 1.
    function automatic int clog2(input int value);
        int width;
        width = 0;
        while ((longint'(1) << width) < longint'(value)) begin
            width = width + 1;
        end
        return width;
    endfunction

endpackage : key_debouncer_pkg
`default_nettype wire

// File: rtl/key_debounce_channel.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | key_debounce_channel                                                     |
// | One key: 2-flop synchroniser, stability counter, level and edge pulses.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module key_debounce_channel
    import key_debouncer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_20MS_100MHZ
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_key_n,
    output key_event_t o_event
);

    localparam int                CNT_W    = clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             level_q, level_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             rise_q,  rise_d;
    logic             fall_q,  fall_d;

    always_comb begin
        sync1_d = i_key_n;
        sync2_d = sync1_q;
        level_d = level_q;
        cnt_d   = cnt_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;

        // Any cycle that agrees with the stable level restarts the count.
        if (sync2_q == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            level_d = sync2_q;
            cnt_d   = '0;
            rise_d  = sync2_q;
            fall_d  = ~sync2_q;
        end else begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign o_event = '{level: level_q, rise: rise_q, fall: fall_q};

endmodule : key_debounce_channel
`default_nettype wire

// File: rtl/key_debouncer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | key_debouncer                                                            |
// | Multi-key push-button front end: polarity fix-up plus per-key debounce.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module key_debouncer
    import key_debouncer_pkg::*;
#(
    parameter int NUM_KEYS        = 5,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_20MS_100MHZ,
    parameter bit ACTIVE_LOW      = 1'b0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_KEYS-1:0] key_raw,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] key_rise,
    output logic [NUM_KEYS-1:0] key_fall
);

    // Normalise to active-high before synchronisation.
    logic [NUM_KEYS-1:0] key_n;
    assign key_n = key_raw ^ {NUM_KEYS{ACTIVE_LOW}};

    generate
        for (genvar i = 0; i < NUM_KEYS; i++) begin : g_chan
            key_event_t chan_event;

            key_debounce_channel #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
            ) u_chan (
                .clk     (clk),
                .reset   (reset),
                .i_key_n (key_n[i]),
                .o_event (chan_event)
            );

            assign key_level[i] = chan_event.level;
            assign key_rise[i]  = chan_event.rise;
            assign key_fall[i]  = chan_event.fall;
        end
    endgenerate

endmodule : key_debouncer
`default_nettype wire

// File: tb/tb_key_debouncer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_key_debouncer                                                         |
// | Timeline scoreboard bench for a 2-key active-high and 1-key active-low.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_key_debouncer;
    import key_debouncer_pkg::*;

    localparam int D = DEBOUNCE_CYCLES_SIM;   // accept edge = D+2 = 6

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [1:0] key_raw = 2'b00;
    logic [1:0] key_level, key_rise, key_fall;
    logic [0:0] al_raw = 1'b1;
    logic [0:0] al_level, al_rise, al_fall;

    int errors = 0;
    int checks = 0;

    logic [8:0] sb[$];
    logic [8:0] obs;
    assign obs = {al_level, al_rise, al_fall, key_level, key_rise, key_fall};

    always #5 clk = ~clk;

    key_debouncer #(.NUM_KEYS(2), .DEBOUNCE_CYCLES(D), .ACTIVE_LOW(1'b0)) dut (
        .clk(clk), .reset(reset), .key_raw(key_raw),
        .key_level(key_level), .key_rise(key_rise), .key_fall(key_fall)
    );

    key_debouncer #(.NUM_KEYS(1), .DEBOUNCE_CYCLES(D), .ACTIVE_LOW(1'b1)) dut_al (
        .clk(clk), .reset(reset), .key_raw(al_raw),
        .key_level(al_level), .key_rise(al_rise), .key_fall(al_fall)
    );

    function automatic logic [8:0] ev(input logic al_l, input logic al_r, input logic al_f,
                                      input logic [1:0] l, input logic [1:0] r,
                                      input logic [1:0] f);
        return {al_l, al_r, al_f, l, r, f};
    endfunction

    // Rise and fall must never coincide on one key.
    always @(negedge clk) begin
        if (!reset) begin
            checks++;
            if (((key_rise & key_fall) !== 2'b00) || ((al_rise & al_fall) !== 1'b0)) begin
                errors++;
                $display("FAIL rise_fall_exclusive: rise=%b fall=%b al_rise=%b al_fall=%b",
                         key_rise, key_fall, al_rise, al_fall);
            end
        end
    end

    task automatic test_reset();
        logic [8:0] e;
        key_raw = 2'b11;
        #2 reset = 1'b1;
        #1 checks++;
        if (obs !== 9'd0) begin
            errors++; $display("FAIL reset_immediate: got %b want %b", obs, 9'd0);
        end
        for (int k = 1; k <= 2; k++) begin
            @(posedge clk); #1 checks++;
            if (obs !== 9'd0) begin
                errors++; $display("FAIL reset_hold edge %0d: got %b want %b", k, obs, 9'd0);
            end
        end
        reset = 1'b0;
        for (int k = 1; k <= 8; k++)
            sb.push_back(ev(0, 0, 0, (k >= 6) ? 2'b11 : 2'b00, (k == 6) ? 2'b11 : 2'b00, 2'b00));
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1 e = sb.pop_front(); checks++;
            if (obs !== e) begin
                errors++; $display("FAIL reset_release_press edge %0d: got %b want %b", k, obs, e);
            end
        end
        key_raw = 2'b00;
        for (int k = 1; k <= 8; k++)
            sb.push_back(ev(0, 0, 0, (k >= 6) ? 2'b00 : 2'b11, 2'b00, (k == 6) ? 2'b11 : 2'b00));
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1 e = sb.pop_front(); checks++;
            if (obs !== e) begin
                errors++; $display("FAIL reset_release_drop edge %0d: got %b want %b", k, obs, e);
            end
        end
    endtask

    task automatic test_step();
        logic [8:0] e;
        key_raw = 2'b01;
        for (int k = 1; k <= 8; k++)
            sb.push_back(ev(0, 0, 0, (k >= 6) ? 2'b01 : 2'b00, (k == 6) ? 2'b01 : 2'b00, 2'b00));
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1 e = sb.pop_front(); checks++;
            if (obs !== e) begin
                errors++; $display("FAIL step_press edge %0d: got %b want %b", k, obs, e);
            end
        end
        key_raw = 2'b00;
        for (int k = 1; k <= 8; k++)
            sb.push_back(ev(0, 0, 0, (k >= 6) ? 2'b00 : 2'b01, 2'b00, (k == 6) ? 2'b01 : 2'b00));
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1 e = sb.pop_front(); checks++;
            if (obs !== e) begin
                errors++; $display("FAIL step_release edge %0d: got %b want %b", k, obs, e);
            end
        end
    endtask

    task automatic test_bounce();
        logic [8:0] e;
        logic [7:0] pattern;
        pattern = 8'b1111_0111;   // bit k-1 = sample k: 1,1,1,0,1,1,1,1
        // Last 0->1 is sampled on edge 5, so acceptance lands on edge 10.
        for (int k = 1; k <= 12; k++)
            sb.push_back(ev(0, 0, 0, (k >= 10) ? 2'b01 : 2'b00, (k == 10) ? 2'b01 : 2'b00, 2'b00));
        for (int k = 1; k <= 12; k++) begin
            key_raw = {1'b0, (k <= 8) ? pattern[k-1] : 1'b1};
            @(posedge clk); #1 e = sb.pop_front(); checks++;
            if (obs !== e) begin
                errors++; $display("FAIL bounce edge %0d: got %b want %b", k, obs, e);
            end
        end
        key_raw = 2'b00;
        for (int k = 1; k <= 8; k++)
            sb.push_back(ev(0, 0, 0, (k >= 6) ? 2'b00 : 2'b01, 2'b00, (k == 6) ? 2'b01 : 2'b00));
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1 e = sb.pop_front(); checks++;
            if (obs !== e) begin
                errors++; $display("FAIL bounce_release edge %0d: got %b want %b", k, obs, e);
            end
        end
    endtask

    task automatic test_glitch();
        logic [8:0] e;
        // 3-cycle excursion: rejected.
        for (int k = 1; k <= 10; k++) sb.push_back(9'd0);
        for (int k = 1; k <= 10; k++) begin
            key_raw = (k <= 3) ? 2'b10 : 2'b00;
            @(posedge clk); #1 e = sb.pop_front(); checks++;
            if (obs !== e) begin
                errors++; $display("FAIL glitch_3 edge %0d: got %b want %b", k, obs, e);
            end
        end
        // Exactly D cycles: accepted on edge 6, released on edge 10.
        for (int k = 1; k <= 12; k++)
            sb.push_back(ev(0, 0, 0, (k >= 6 && k < 10) ? 2'b10 : 2'b00,
                            (k == 6) ? 2'b10 : 2'b00, (k == 10) ? 2'b10 : 2'b00));
        for (int k = 1; k <= 12; k++) begin
            key_raw = (k <= 4) ? 2'b10 : 2'b00;
            @(posedge clk); #1 e = sb.pop_front(); checks++;
            if (obs !== e) begin
                errors++; $display("FAIL glitch_4 edge %0d: got %b want %b", k, obs, e);
            end
        end
    endtask

    task automatic test_simultaneous();
        logic [8:0] e;
        key_raw = 2'b11;
        for (int k = 1; k <= 8; k++)
            sb.push_back(ev(0, 0, 0, (k >= 6) ? 2'b11 : 2'b00, (k == 6) ? 2'b11 : 2'b00, 2'b00));
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1 e = sb.pop_front(); checks++;
            if (obs !== e) begin
                errors++; $display("FAIL simultaneous_press edge %0d: got %b want %b", k, obs, e);
            end
        end
        key_raw = 2'b00;
        for (int k = 1; k <= 8; k++)
            sb.push_back(ev(0, 0, 0, (k >= 6) ? 2'b00 : 2'b11, 2'b00, (k == 6) ? 2'b11 : 2'b00));
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1 e = sb.pop_front(); checks++;
            if (obs !== e) begin
                errors++; $display("FAIL simultaneous_release edge %0d: got %b want %b", k, obs, e);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [8:0] e;
        key_raw = 2'b10;
        for (int k = 1; k <= 8; k++)
            sb.push_back(ev(0, 0, 0, (k >= 6) ? 2'b10 : 2'b00, (k == 6) ? 2'b10 : 2'b00, 2'b00));
        // Key 0 then counts to 2 (edges 3 and 4) before reset hits.
        for (int k = 1; k <= 4; k++) sb.push_back(ev(0, 0, 0, 2'b10, 2'b00, 2'b00));
        for (int k = 1; k <= 12; k++) begin
            if (k == 9) key_raw = 2'b11;
            @(posedge clk); #1 e = sb.pop_front(); checks++;
            if (obs !== e) begin
                errors++; $display("FAIL reset_mid_setup edge %0d: got %b want %b", k, obs, e);
            end
        end
        #2 reset = 1'b1;
        #1 checks++;
        if (obs !== 9'd0) begin
            errors++; $display("FAIL reset_mid_immediate: got %b want %b", obs, 9'd0);
        end
        @(posedge clk); #1 reset = 1'b0;
        for (int k = 1; k <= 8; k++)
            sb.push_back(ev(0, 0, 0, (k >= 6) ? 2'b11 : 2'b00, (k == 6) ? 2'b11 : 2'b00, 2'b00));
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1 e = sb.pop_front(); checks++;
            if (obs !== e) begin
                errors++; $display("FAIL reset_mid_relatency edge %0d: got %b want %b", k, obs, e);
            end
        end
        key_raw = 2'b00;
        for (int k = 1; k <= 8; k++)
            sb.push_back(ev(0, 0, 0, (k >= 6) ? 2'b00 : 2'b11, 2'b00, (k == 6) ? 2'b11 : 2'b00));
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1 e = sb.pop_front(); checks++;
            if (obs !== e) begin
                errors++; $display("FAIL reset_mid_release edge %0d: got %b want %b", k, obs, e);
            end
        end
    endtask

    task automatic test_active_low();
        logic [8:0] e;
        al_raw = 1'b0;
        for (int k = 1; k <= 8; k++)
            sb.push_back(ev(k >= 6, k == 6, 1'b0, 2'b00, 2'b00, 2'b00));
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1 e = sb.pop_front(); checks++;
            if (obs !== e) begin
                errors++; $display("FAIL active_low_press edge %0d: got %b want %b", k, obs, e);
            end
        end
        al_raw = 1'b1;
        for (int k = 1; k <= 8; k++)
            sb.push_back(ev(k < 6, 1'b0, k == 6, 2'b00, 2'b00, 2'b00));
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1 e = sb.pop_front(); checks++;
            if (obs !== e) begin
                errors++; $display("FAIL active_low_release edge %0d: got %b want %b", k, obs, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_step();
        test_bounce();
        test_glitch();
        test_simultaneous();
        test_reset_mid();
        test_active_low();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_key_debouncer
`default_nettype wire
